// File: rtl/alu_wb_buffer.sv
// Small FIFO between the ALU result interface and the scoreboard writeback port.
// Decouples single-cycle ALU results from writeback arbitration stalls.
module alu_wb_buffer #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DEPTH         = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       alu_valid_i,
  output logic                       alu_ready_o,
  input  logic [TRANS_ID_BITS-1:0]   alu_trans_id_i,
  input  logic [XLEN-1:0]            alu_result_i,
  input  logic                       alu_is_branch_i,
  input  logic                       alu_branch_res_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic [XLEN-1:0]            wb_result_o,
  output logic                       wb_is_branch_o,
  output logic                       wb_branch_res_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [TRANS_ID_BITS-1:0] trans_id_q   [DEPTH];
  logic [XLEN-1:0]          result_q     [DEPTH];
  logic                     is_branch_q  [DEPTH];
  logic                     branch_res_q [DEPTH];
  logic [DEPTH-1:0]         valid_q, valid_d;

  logic full, empty, push, pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  assign alu_ready_o = ~full;
  assign wb_valid_o  = ~empty;

  assign push = alu_valid_i & ~full;
  assign pop  = wb_valid_o & wb_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d          = rd_ptr_q + PtrW'(1);
        valid_d[rd_ptr_q] = 1'b0;
      end
      if (push) begin
        wr_ptr_d          = wr_ptr_q + PtrW'(1);
        valid_d[wr_ptr_q] = 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload needs no flush: entries are only observable through count_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        trans_id_q[i]   <= '0;
        result_q[i]     <= '0;
        is_branch_q[i]  <= 1'b0;
        branch_res_q[i] <= 1'b0;
      end
    end else if (push && !flush_i) begin
      trans_id_q[wr_ptr_q]   <= alu_trans_id_i;
      result_q[wr_ptr_q]     <= alu_result_i;
      is_branch_q[wr_ptr_q]  <= alu_is_branch_i;
      branch_res_q[wr_ptr_q] <= alu_branch_res_i;
    end
  end

  always_comb begin
    wb_trans_id_o   = '0;
    wb_result_o     = '0;
    wb_is_branch_o  = 1'b0;
    wb_branch_res_o = 1'b0;
    if (wb_valid_o) begin
      wb_trans_id_o   = trans_id_q[rd_ptr_q];
      wb_result_o     = result_q[rd_ptr_q];
      wb_is_branch_o  = is_branch_q[rd_ptr_q];
      wb_branch_res_o = branch_res_q[rd_ptr_q];
    end
  end

  assign count_o = count_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push && full))
        else $error("alu_wb_buffer: push while full");
      assert (valid_q[rd_ptr_q] == wb_valid_o)
        else $error("alu_wb_buffer: head valid bit disagrees with occupancy");
    end
  end
`endif

endmodule

// File: doc/alu_wb_buffer.md
Name: alu_wb_buffer

Overview:
- Receiving end of the ALU result interface. It captures each single-cycle ALU result, together with its transaction ID and branch outcome, into a small FIFO.
- It presents the buffered results to the scoreboard writeback port under a valid/ready handshake.
- Purpose: decouple ALU issue from writeback-port arbitration, so a stalled writeback never corrupts an ALU result already produced.
- Sits between the ALU and the scoreboard write port inside the execute stage.

Parameters:
- XLEN, 64, data width of the result path (32 or 64).
- TRANS_ID_BITS, 3, width of the scoreboard transaction ID.
- DEPTH, 2, number of FIFO entries; power of two, at least 2.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  asynchronous active-high reset.
- flush_i  input  1  synchronous flush; discards all buffered entries.
- alu_valid_i  input  1  ALU presents a result this cycle.
- alu_ready_o  output  1  buffer can accept a result this cycle.
- alu_trans_id_i  input  TRANS_ID_BITS  transaction ID of the incoming result.
- alu_result_i  input  XLEN  ALU result value.
- alu_is_branch_i  input  1  incoming op is a branch comparison.
- alu_branch_res_i  input  1  branch comparison outcome.
- wb_valid_o  output  1  head entry valid.
- wb_ready_i  input  1  scoreboard accepts head entry.
- wb_trans_id_o  output  TRANS_ID_BITS  head transaction ID.
- wb_result_o  output  XLEN  head result.
- wb_is_branch_o  output  1  head is a branch.
- wb_branch_res_o  output  1  head branch outcome.
- count_o  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Interface: already decided — one clock (clk_i); reset rst_i is asynchronous, active-high.
- Reset values:
  - Pointers and count are 0; all entry valid bits are 0.
  - wb_valid_o=0, count_o=0, alu_ready_o=1.
  - Data outputs are 0.
- Storage: circular FIFO with read pointer, write pointer and occupancy counter.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: alu_valid_i & alu_ready_o.
  - The entry is written at the write pointer; the pointer increments.
- Pop: wb_valid_o & wb_ready_i.
  - The read pointer increments.
- alu_ready_o = (count != DEPTH).
  - It is combinational from state only; there is no path from wb_ready_i to alu_ready_o.
- wb_valid_o = (count != 0).
  - The wb_* data outputs are driven from the entry at the read pointer.
  - They are zero when the buffer is empty.
- Latency: a result pushed in cycle N is visible on wb_* in cycle N+1 at the earliest. There is no same-cycle bypass.
- Ordering: strict FIFO; results retire in push order.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged; both pointers advance.
- Full (count==DEPTH):
  - alu_ready_o=0, including when a pop happens in the same cycle.
  - A push offered while full is not accepted. Holding it is the ALU-side issue logic's responsibility.
- Empty: a pop is impossible because wb_valid_o=0; wb_ready_i is ignored.
- Flush:
  - At the next edge, count, pointers and entry valid bits become 0.
  - Flush overrides a same-cycle push and pop; the pushed result is dropped.
  - In the cycle after flush, wb_valid_o=0 and alu_ready_o=1.
- Asynchronous reset mid-operation: all state clears immediately and all buffered results are lost.
- Stability: while wb_valid_o=1 and wb_ready_i=0, all wb_* outputs hold stable.
- Width rules:
  - wb_result_o is passed through bit-exact; no sign extension or truncation.
  - count_o is exactly $clog2(DEPTH+1) bits.
- Assertion (simulation only): a push while count==DEPTH is an error.

Test Plan:
- Single result, no backpressure:
  - Stimulus: after reset, push id=3, result=0x0000_0000_DEAD_BEEF with wb_ready_i=1.
  - Required: next cycle wb_valid_o=1, wb_trans_id_o=3, wb_result_o=0xDEADBEEF. The following cycle wb_valid_o=0 and count_o=0.
- Fill to full under backpressure:
  - Stimulus: with wb_ready_i=0, push id=1 then id=2.
  - Required: count_o=2 and alu_ready_o=0. Head stays id=1 with a stable result.
  - Then raise wb_ready_i: retires id=1, then id=2, in order.
- Simultaneous push and pop at count=1, repeated for 8 cycles with incrementing IDs:
  - Required: count_o stays 1 and pointers wrap correctly.
  - Output IDs equal input IDs delayed by one handshake; none lost or duplicated.
- Branch result:
  - Stimulus: push is_branch=1, branch_res=0, id=5.
  - Required: wb_is_branch_o=1, wb_branch_res_o=0, wb_trans_id_o=5.
- Flush colliding with push:
  - Stimulus: with count=2, assert flush_i together with alu_valid_i.
  - Required: next cycle count_o=0, wb_valid_o=0, alu_ready_o=1, and the pushed entry never appears.
- Async reset mid-stream:
  - Stimulus: with count=1, assert rst_i between edges.
  - Required: wb_valid_o=0 and count_o=0 immediately. After release, a fresh push of id=7 appears one cycle later.
